// File: rtl/conv_sched.sv
// Raster window scheduler for the 3x3 conv array: issues patch requests under output-FIFO
// credit, tracks them through the fixed-latency array and tags results. CONV_SCHED_PERF_EN adds stall_cnt_o.
module conv_sched #(
  parameter int IMG_W      = 16,
  parameter int IMG_H      = 16,
  parameter int ARRAY_LAT  = 18,
  parameter int FIFO_DEPTH = 4,
  parameter int COORD_W    = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               win_req_o,
  output logic [COORD_W-1:0] win_row_o,
  output logic [COORD_W-1:0] win_col_o,
  input  logic               win_ack_i,
  output logic               res_valid_o,
  output logic [COORD_W-1:0] res_row_o,
  output logic [COORD_W-1:0] res_col_o,
  input  logic               res_pop_i
`ifdef CONV_SCHED_PERF_EN
  ,
  output logic [31:0]        stall_cnt_o
`endif
);
  localparam int CRED_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(IMG_W - 3);
  localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(IMG_H - 3);
  localparam logic [CRED_W-1:0]  CRED_MAX = CRED_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  state_t state, state_nxt;

  logic [CRED_W-1:0]    credit;
  logic [ARRAY_LAT-1:0] vld_pipe;
  logic                 accept, launch, iss_last, res_last;

  assign win_req_o   = (state == S_RUN) && (credit != '0);
  assign accept      = win_req_o && win_ack_i;
  assign launch      = (state == S_IDLE) && start_i;
  assign iss_last    = (win_row_o == LAST_ROW) && (win_col_o == LAST_COL);
  assign res_last    = res_valid_o && (res_row_o == LAST_ROW) && (res_col_o == LAST_COL);
  assign res_valid_o = vld_pipe[ARRAY_LAT-1];

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= S_IDLE;
    else       state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_i) state_nxt = S_RUN;
      S_RUN:   if (accept && iss_last) state_nxt = S_DRAIN;
      S_DRAIN: if (res_last) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      busy_o <= (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
      done_o <= (state_nxt == S_DONE);
    end

  // Each credit is one free FIFO slot; pops beyond the FIFO depth are spurious and dropped.
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i)                                            credit <= CRED_MAX;
    else if (launch)                                      credit <= CRED_MAX;
    else if (accept && !res_pop_i)                        credit <= credit - 1'b1;
    else if (!accept && res_pop_i && credit != CRED_MAX)  credit <= credit + 1'b1;

  // Issue coordinate parks on the last window once it has been accepted.
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      win_row_o <= '0;
      win_col_o <= '0;
    end else if (launch) begin
      win_row_o <= '0;
      win_col_o <= '0;
    end else if (accept && !iss_last) begin
      if (win_col_o == LAST_COL) begin
        win_col_o <= '0;
        win_row_o <= win_row_o + 1'b1;
      end else begin
        win_col_o <= win_col_o + 1'b1;
      end
    end

  // The array cannot stall, so a plain shift register mirrors its occupancy.
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) vld_pipe <= '0;
    else       vld_pipe <= ARRAY_LAT'({vld_pipe, accept});

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      res_row_o <= '0;
      res_col_o <= '0;
    end else if (launch || res_last) begin
      res_row_o <= '0;
      res_col_o <= '0;
    end else if (res_valid_o) begin
      if (res_col_o == LAST_COL) begin
        res_col_o <= '0;
        res_row_o <= res_row_o + 1'b1;
      end else begin
        res_col_o <= res_col_o + 1'b1;
      end
    end

`ifdef CONV_SCHED_PERF_EN
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i)       stall_cnt_o <= '0;
    else if (launch) stall_cnt_o <= '0;
    else if (state == S_RUN && !accept && stall_cnt_o != '1)
      stall_cnt_o <= stall_cnt_o + 1'b1;
`endif

endmodule
